vx_rsp_reorder: RTL and testbench

VX_RSP_REORDER -- requirements
Module: VX_rsp_reorder

---
 rtl/vx_rsp_reorder.sv | 124 ++++++++++++
 tb/tb_vx_rsp_reorder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_rsp_reorder.sv
// Response reorder buffer: hands out tags in order, accepts responses out of
// order, and retires payloads strictly in allocation order.
module vx_rsp_reorder #(
  parameter int DATAW     = 1,
  parameter int SIZE      = 4,
  parameter int LUTRAM    = 1,
  parameter int ADDRW     = $clog2(SIZE),
  parameter bit RSP_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [ADDRW-1:0] alloc_tag,
  input  logic             rsp_valid,
  input  logic [ADDRW-1:0] rsp_tag,
  input  logic [DATAW-1:0] rsp_data,
  output logic             out_valid,
  output logic [ADDRW-1:0] out_tag,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic             empty,
  output logic             full,
  output logic [ADDRW:0]   count
);

  localparam int PW = ADDRW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{ADDRW{1'b0}}, 1'b1};

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [SIZE-1:0]  done_q, done_d;
  logic [DATAW-1:0] mem_q [SIZE];
  logic [ADDRW-1:0] head_slot_s, tail_slot_s, rsp_off_s;
  logic             alloc_fire_s, out_fire_s, rsp_ok_s;

  assign head_slot_s = head_q[ADDRW-1:0];
  assign tail_slot_s = tail_q[ADDRW-1:0];

  assign count       = tail_q - head_q;
  assign empty       = (head_q == tail_q);
  assign full        = (head_slot_s == tail_slot_s) && (head_q[ADDRW] != tail_q[ADDRW]);
  assign alloc_ready = ~full;
  assign alloc_tag   = tail_slot_s;
  assign out_valid   = done_q[head_slot_s];
  assign out_tag     = head_slot_s;

  assign alloc_fire_s = alloc_valid & ~full;
  assign out_fire_s   = out_valid & out_ready;

  // A response is legal only for a slot inside the allocated window that is still pending.
  assign rsp_off_s = rsp_tag - head_slot_s;
  assign rsp_ok_s  = rsp_valid & ({1'b0, rsp_off_s} < count) & ~done_q[rsp_tag];

  // Next-state for pointers and done bits; the three operations never share a slot.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    done_d = done_q;
    if (out_fire_s) begin
      head_d              = head_q + PTR_ONE;
      done_d[head_slot_s] = 1'b0;
    end else begin
      head_d = head_q;
    end
    if (alloc_fire_s) begin
      tail_d              = tail_q + PTR_ONE;
      done_d[tail_slot_s] = 1'b0;
    end else begin
      tail_d = tail_q;
    end
    if (rsp_ok_s) begin
      done_d[rsp_tag] = 1'b1;
    end else begin
      done_d[rsp_tag] = done_d[rsp_tag];
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      done_q <= done_d;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rsp_ok_s) begin
      mem_q[rsp_tag] <= rsp_data;
    end
  end

  if (LUTRAM != 0) begin : g_lutram
    assign out_data = mem_q[head_slot_s];
  end else begin : g_bram
    logic [DATAW-1:0] rdata_q;
    logic [ADDRW-1:0] raddr_s;
    assign raddr_s = head_d[ADDRW-1:0];
    // Registered read of the next head slot, write-first so a fresh response is seen.
    always_ff @(posedge clk) begin
      if (rsp_ok_s && (rsp_tag == raddr_s)) begin
        rdata_q <= rsp_data;
      end else begin
        rdata_q <= mem_q[raddr_s];
      end
    end
    assign out_data = rdata_q;
  end

`ifndef SYNTHESIS
  // Flag responses that are dropped as illegal.
  always_ff @(posedge clk) begin
    if (RSP_CHECK && rsp_valid && !rsp_ok_s) begin
      $error("vx_rsp_reorder: illegal response to tag %0d", rsp_tag);
    end
  end
`endif

endmodule

// File: tb/tb_vx_rsp_reorder.sv
// Self-checking bench for vx_rsp_reorder against an in-order queue model.
module tb_vx_rsp_reorder;

  localparam int DATAW = 8;
  localparam int SIZE  = 4;
  localparam int ADDRW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             alloc_valid, alloc_ready;
  logic [ADDRW-1:0] alloc_tag;
  logic             rsp_valid;
  logic [ADDRW-1:0] rsp_tag;
  logic [DATAW-1:0] rsp_data;
  logic             out_valid, out_ready;
  logic [ADDRW-1:0] out_tag;
  logic [DATAW-1:0] out_data;
  logic             empty, full;
  logic [ADDRW:0]   count;

  int checks = 0;
  int errors = 0;

  // Model: queue of outstanding tags in allocation order, plus done/data per tag.
  int               q_tag[$];
  bit               m_done[SIZE];
  logic [DATAW-1:0] m_data[SIZE];
  int               m_tail = 0;

  always #5 clk = ~clk;

  vx_rsp_reorder #(
    .DATAW(DATAW), .SIZE(SIZE), .LUTRAM(1), .ADDRW(ADDRW), .RSP_CHECK(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .out_ready(out_ready),
    .empty(empty), .full(full), .count(count)
  );

  function automatic bit m_has(int t);
    foreach (q_tag[i]) if (q_tag[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    alloc_valid = 1'b0; rsp_valid = 1'b0; rsp_tag = '0; rsp_data = '0; out_ready = 1'b0;
  endtask

  task automatic m_reset();
    q_tag.delete();
    for (int i = 0; i < SIZE; i++) m_done[i] = 1'b0;
    m_tail = 0;
  endtask

  // Advance one clock with the current inputs and apply the same effects to the model.
  task automatic clk_step();
    bit af, of, rf;
    int rt;
    logic [DATAW-1:0] rd;
    af = alloc_valid && (q_tag.size() < SIZE);
    of = 1'b0;
    if (q_tag.size() > 0) of = out_ready && m_done[q_tag[0]];
    rt = int'(rsp_tag);
    rd = rsp_data;
    rf = rsp_valid && m_has(rt) && !m_done[rt];
    @(posedge clk); #1;
    if (of) begin m_done[q_tag[0]] = 1'b0; void'(q_tag.pop_front()); end
    if (rf) begin m_done[rt] = 1'b1; m_data[rt] = rd; end
    if (af) begin q_tag.push_back(m_tail); m_done[m_tail] = 1'b0; m_tail = (m_tail + 1) % SIZE; end
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(negedge clk); reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); end
    checks++; if (alloc_tag !== 2'd0) begin errors++; $display("FAIL reset_alloc_tag got %0d exp 0", alloc_tag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_tag !== 2'd0) begin errors++; $display("FAIL reset_out_tag got %0d exp 0", out_tag); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    @(posedge clk); @(negedge clk); reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reorder();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      checks++; if (alloc_tag !== ADDRW'(i)) begin errors++; $display("FAIL reorder_alloc_tag got %0d exp %0d", alloc_tag, i); end
      clk_step();
    end
    alloc_valid = 1'b0;
    rsp_valid = 1'b1; rsp_tag = 2'd2; rsp_data = 8'hA1; clk_step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reorder_wait_head got %b exp 0", out_valid); end
    rsp_tag = 2'd0; rsp_data = 8'hB2; clk_step();
    checks++; if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_data !== 8'hB2) begin errors++;
      $display("FAIL reorder_out0 got v=%b t=%0d d=%h exp 1/0/b2", out_valid, out_tag, out_data); end
    rsp_tag = 2'd1; rsp_data = 8'hC3; clk_step();
    rsp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_data !== 8'hC3) begin errors++;
      $display("FAIL reorder_out1 got v=%b t=%0d d=%h exp 1/1/c3", out_valid, out_tag, out_data); end
    clk_step();
    checks++; if (out_valid !== 1'b1 || out_tag !== 2'd2 || out_data !== 8'hA1) begin errors++;
      $display("FAIL reorder_out2 got v=%b t=%0d d=%h exp 1/2/a1", out_valid, out_tag, out_data); end
    clk_step();
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reorder_drained got empty=%b v=%b exp 1/0", empty, out_valid); end
  endtask

  task automatic test_full();
    apply_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) clk_step();
    alloc_valid = 1'b0;
    checks++; if (full !== 1'b1 || count !== 3'd4 || alloc_ready !== 1'b0) begin errors++;
      $display("FAIL full_state got full=%b count=%0d ready=%b exp 1/4/0", full, count, alloc_ready); end
    rsp_valid = 1'b1; rsp_tag = 2'd0; rsp_data = 8'h5A; clk_step();
    rsp_valid = 1'b0; alloc_valid = 1'b1; out_ready = 1'b1;
    checks++; if (alloc_ready !== 1'b0 || out_valid !== 1'b1) begin errors++;
      $display("FAIL full_no_bypass got ready=%b v=%b exp 0/1", alloc_ready, out_valid); end
    clk_step();
    out_ready = 1'b0;
    checks++; if (full !== 1'b0 || count !== 3'd3 || alloc_tag !== 2'd0 || out_tag !== 2'd1) begin errors++;
      $display("FAIL full_after_retire got full=%b count=%0d atag=%0d otag=%0d exp 0/3/0/1", full, count, alloc_tag, out_tag); end
    clk_step();
    alloc_valid = 1'b0;
    checks++; if (full !== 1'b1 || count !== 3'd4 || alloc_tag !== 2'd1) begin errors++;
      $display("FAIL full_realloc got full=%b count=%0d atag=%0d exp 1/4/1", full, count, alloc_tag); end
  endtask

  task automatic test_stall();
    apply_reset();
    alloc_valid = 1'b1; clk_step(); clk_step(); alloc_valid = 1'b0;
    rsp_valid = 1'b1; rsp_tag = 2'd1; rsp_data = 8'h11; clk_step();
    rsp_tag = 2'd0; rsp_data = 8'h22; clk_step();
    rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_data !== 8'h22 || count !== 3'd2) begin errors++;
        $display("FAIL stall_hold cyc %0d got v=%b t=%0d d=%h c=%0d exp 1/0/22/2", i, out_valid, out_tag, out_data, count); end
      clk_step();
    end
    out_ready = 1'b1; clk_step(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_data !== 8'h11) begin errors++;
      $display("FAIL stall_release got v=%b t=%0d d=%h exp 1/1/11", out_valid, out_tag, out_data); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) clk_step();
    alloc_valid = 1'b0;
    rsp_valid = 1'b1; rsp_tag = 2'd0; rsp_data = 8'h77; clk_step();
    rsp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL areset_pre got v=%b c=%0d exp 1/3", out_valid, count); end
    #2 reset = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || count !== 3'd0 || alloc_tag !== 2'd0 || full !== 1'b0) begin errors++;
      $display("FAIL areset_immediate got v=%b e=%b c=%0d at=%0d f=%b exp 0/1/0/0/0", out_valid, empty, count, alloc_tag, full); end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    m_reset();
  endtask

  task automatic test_illegal_rsp();
    apply_reset();
    rsp_valid = 1'b1; rsp_tag = 2'd3; rsp_data = 8'hEE; clk_step();
    rsp_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin errors++;
      $display("FAIL illegal_unalloc got v=%b c=%0d e=%b exp 0/0/1", out_valid, count, empty); end
    alloc_valid = 1'b1; clk_step(); alloc_valid = 1'b0;
    rsp_valid = 1'b1; rsp_tag = 2'd0; rsp_data = 8'h55; clk_step();
    rsp_data = 8'h66; clk_step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin errors++;
      $display("FAIL illegal_redone got v=%b d=%h exp 1/55", out_valid, out_data); end
    rsp_tag = 2'd2; rsp_data = 8'h99; clk_step();
    rsp_valid = 1'b0;
    checks++; if (count !== 3'd1 || out_tag !== 2'd0 || out_data !== 8'h55) begin errors++;
      $display("FAIL illegal_beyond got c=%0d t=%0d d=%h exp 1/0/55", count, out_tag, out_data); end
    out_ready = 1'b1; clk_step(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      alloc_valid = (i < 10);
      rsp_valid   = (i >= 1 && i <= 10);
      rsp_tag     = ADDRW'((i + 3) % SIZE);
      rsp_data    = DATAW'((i - 1) * 17 + 3);
      if (i < 10) begin
        checks++; if (alloc_tag !== ADDRW'(i % SIZE) || alloc_ready !== 1'b1) begin errors++;
          $display("FAIL b2b_alloc round %0d got t=%0d r=%b exp %0d/1", i, alloc_tag, alloc_ready, i % SIZE); end
      end
      if (i >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_tag !== ADDRW'((i - 2) % SIZE) || out_data !== DATAW'((i - 2) * 17 + 3)) begin errors++;
          $display("FAIL b2b_out round %0d got v=%b t=%0d d=%h exp 1/%0d/%h", i, out_valid, out_tag, out_data, (i - 2) % SIZE, DATAW'((i - 2) * 17 + 3)); end
      end
      checks++; if (count > 3'd4) begin errors++; $display("FAIL b2b_count round %0d got %0d exp <=4", i, count); end
      clk_step();
    end
    idle_inputs();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", empty); end
  endtask

  task automatic test_random();
    bit ev;
    int pend[$];
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      ev = 1'b0;
      if (q_tag.size() > 0) ev = m_done[q_tag[0]];
      checks++; if (alloc_ready !== (q_tag.size() < SIZE) || alloc_tag !== ADDRW'(m_tail)) begin errors++;
        $display("FAIL rand_alloc cyc %0d got r=%b t=%0d exp %b/%0d", n, alloc_ready, alloc_tag, q_tag.size() < SIZE, m_tail); end
      checks++; if (count !== 3'(q_tag.size()) || empty !== (q_tag.size() == 0) || full !== (q_tag.size() == SIZE)) begin errors++;
        $display("FAIL rand_occupancy cyc %0d got c=%0d e=%b f=%b exp c=%0d", n, count, empty, full, q_tag.size()); end
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL rand_out_valid cyc %0d got %b exp %b", n, out_valid, ev); end
      if (ev) begin
        checks++; if (out_tag !== ADDRW'(q_tag[0]) || out_data !== m_data[q_tag[0]]) begin errors++;
          $display("FAIL rand_out_payload cyc %0d got t=%0d d=%h exp %0d/%h", n, out_tag, out_data, q_tag[0], m_data[q_tag[0]]); end
      end
      pend.delete();
      foreach (q_tag[i]) if (!m_done[q_tag[i]]) pend.push_back(q_tag[i]);
      alloc_valid = ($urandom_range(0, 99) < 55);
      out_ready   = ($urandom_range(0, 99) < 60);
      rsp_data    = DATAW'($urandom);
      rsp_valid   = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 99) < 70) begin
        rsp_valid = 1'b1;
        rsp_tag   = ADDRW'(pend[$urandom_range(0, pend.size() - 1)]);
      end else if ($urandom_range(0, 99) < 10) begin
        rsp_valid = 1'b1;
        rsp_tag   = ADDRW'($urandom_range(0, SIZE - 1));
      end
      clk_step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_reset();
    test_reset();
    test_reorder();
    test_full();
    test_stall();
    test_async_reset();
    test_illegal_rsp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
